me_block_loader: RTL and testbench
==================================

# me_block_loader

Upstream feeder for the full-search motion-estimation engine (`top`). It accepts a byte stream holding one 16×16 reference block and one 32×32 search window, and stores them in internal memories. Those memories serve the engine's three combinational read ports (`AddressR`/`R`, `AddressS1`/`S1`, `AddressS2`/`S2`). The block then drives `start`, waits for `completed`, captures the best distance and motion vector, and presents them on a valid/ready result port.

## Interface
Parameters:
- `RUN_TIMEOUT`, default 4200: maximum cycles in RUN before aborting; must exceed 4112.

Ports:
- `clock`  in  1  sole clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  stream byte valid.
- `in_ready`  out  1  loader accepts a byte; high only in LOAD_R and LOAD_S.
- `in_data`  in  8  pixel byte: 256 R bytes (raster), then 1024 S bytes (raster, 32 per row).
- `in_last`  in  1  marks the final (1280th) byte of a frame.
- `start`  out  1  engine run level to `top`.
- `completed`  in  1  engine done flag from `top`.
- `bestDistance`  in  8  engine result.
- `motionX`  in  4  engine result.
- `motionY`  in  4  engine result.
- `AddressR`  in  8  engine read address for R memory.
- `R`  out  8  `Rmem[AddressR]`, combinational.
- `AddressS1`  in  10  engine read address for S memory.
- `AddressS2`  in  10  engine read address for S memory.
- `S1`  out  8  `Smem[AddressS1]`, combinational.
- `S2`  out  8  `Smem[AddressS2]`, combinational.
- `res_valid`  out  1  result held valid.
- `res_ready`  in  1  result consumer ready.
- `res_dist`  out  8  captured `bestDistance`.
- `res_mx`  out  4  captured `motionX`.
- `res_my`  out  4  captured `motionY`.
- `err`  out  1  sticky error: `in_last` mismatch or timeout. Cleared only by reset.

## Operation
- States: LOAD_R, LOAD_S, RUN, SETTLE, RESULT. Reset state is LOAD_R.
- LOAD_R: each accepted byte (`in_valid && in_ready`) is written to `Rmem[wcnt[7:0]]`. When `wcnt` reaches 255 on an accepted byte, go to LOAD_S with `wcnt` set to 0.
- LOAD_S: accepted bytes are written to `Smem[wcnt]`. The byte at `wcnt`==1023 moves the FSM to RUN.
- `in_last` check:
  - `in_last` asserted on any accepted byte other than the 1280th sets `err`.
  - `in_last` deasserted on the 1280th byte also sets `err`.
  - Either way, framing proceeds purely by count.
- RUN: `start`=1. `tcnt` counts from 0.
  - `completed`=1 → SETTLE.
  - `tcnt`==`RUN_TIMEOUT`-1 without `completed` → set `err`, drop `start`, return to LOAD_R. No result is produced.
- SETTLE: exactly one cycle with `start` still 1. This lets the comparator's final posedge update land.
- Leaving SETTLE: capture `bestDistance`, `motionX`, `motionY` into the `res_*` registers, set `res_valid`=1, enter RESULT.
- RESULT: `start` stays 1, so the engine holds its count and outputs. On `res_valid && res_ready`: clear `res_valid`, drop `start` (which resets the engine counter), go to LOAD_R.
- Memories are not reset and are not cleared between frames; each frame overwrites them fully.
- Read ports are valid in every state, but are meaningful only after the memories are loaded.

## Timing
- Reset values: `in_ready`=1 (LOAD_R), `start`=0, `res_valid`=0, `res_dist`=8'hFF, `res_mx`=0, `res_my`=0, `err`=0, `wcnt`=0, `tcnt`=0.
- `in_ready` is registered-state-derived (decoded from the FSM state) and does not depend on `in_valid`.
- Throughput is one byte per cycle. A frame load takes 1280 accepted cycles.
- `start` rises the cycle after the 1280th byte is accepted.
- `res_valid` rises 2 cycles after `completed` is first sampled high.
- The `res_*` outputs are stable while `res_valid`=1.
- `in_ready` rises the cycle after the result handshake.
- Reset mid-operation (any state): return to LOAD_R immediately. `start` drops asynchronously; any partial frame is discarded.
- `completed` outside RUN is ignored.

## Structure
- Shared package `me_pkg`:
  - constants `R_BYTES`=256, `S_BYTES`=1024, `COUNT_COMPLETE`=4111;
  - state enum `loader_state_t`.
- One sub-module, `me_pixel_ram`: parameterised depth, one write port, N combinational read ports. Instantiate it once for R (1 read port) and once for S (2 read ports).

## Test plan
- Uniform frame: all R and S bytes = 8'h10, `res_ready` held 1, driving real `top` → `res_dist`=8'h00, `res_valid` for one cycle, then `in_ready`=1.
- Backpressure: `in_valid` toggled 50%; `res_ready` low for 20 cycles → exactly 1280 writes; `res_*` stable for all 20 cycles; `start` stays 1 until the handshake.
- Framing: `in_last` on byte 1000 → `err`=1, load still completes at byte 1280. A clean following frame leaves `err`=1 (sticky).
- Timeout: stub `completed`=0 → `start` falls after exactly 4200 RUN cycles, `err`=1, `res_valid` never rises.
- Memory readback: load R=index, S=index[7:0]; with `AddressS1`=10'd37 and `AddressS2`=10'd1023 → `S1`=8'd37, `S2`=8'hFF; `AddressR`=8'd200 → `R`=8'd200.
- Reset during RUN at cycle 100 → `start`=0, `in_ready`=1 immediately; the next full frame runs normally.

Source files
------------

// File: rtl/me_pkg.sv
// Shared constants and FSM state type for the motion-estimation loader.
// Used by me_block_loader and its pixel memories.
package me_pkg;
  localparam int R_BYTES        = 256;
  localparam int S_BYTES        = 1024;
  localparam int COUNT_COMPLETE = 4111;

  typedef enum logic [2:0] {
    LOAD_R,
    LOAD_S,
    RUN,
    SETTLE,
    RESULT
  } loader_state_t;
endpackage

// File: rtl/me_pixel_ram.sv
// Byte-wide pixel memory: one sync write port, NRD comb read ports.
// Ports: clk_i, we_i/waddr_i/wdata_i write; raddr_i/rdata_o reads.
module me_pixel_ram #(
  parameter int DEPTH = 256,
  parameter int NRD   = 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  logic [7:0]              wdata_i,
  input  logic [NRD-1:0][AW-1:0]  raddr_i,
  output logic [NRD-1:0][7:0]     rdata_o
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdata_o[i] = mem_q[raddr_i[i]];
    end
  end
endmodule

// File: rtl/me_block_loader.sv
// Loads R/S pixel memories from a byte stream, runs the ME engine,
// returns best distance/motion on a valid/ready port; err is sticky.
module me_block_loader
  import me_pkg::*;
#(
  parameter int RUN_TIMEOUT = 4200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       start,
  input  logic       completed,
  input  logic [7:0] bestDistance,
  input  logic [3:0] motionX,
  input  logic [3:0] motionY,
  input  logic [7:0] AddressR,
  output logic [7:0] R,
  input  logic [9:0] AddressS1,
  input  logic [9:0] AddressS2,
  output logic [7:0] S1,
  output logic [7:0] S2,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_dist,
  output logic [3:0] res_mx,
  output logic [3:0] res_my,
  output logic       err
);
  localparam int TW = $clog2(RUN_TIMEOUT);

  loader_state_t state_q, state_d;
  logic [9:0]    wcnt_q, wcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic [7:0]    dist_q, dist_d;
  logic [3:0]    mx_q, mx_d;
  logic [3:0]    my_q, my_d;
  logic          accept;
  logic          is_final;
  logic [1:0][7:0] s_rd;

  // Outputs decode straight from state so reset drops start at once.
  assign in_ready  = (state_q == LOAD_R) || (state_q == LOAD_S);
  assign start     = (state_q == RUN) || (state_q == SETTLE)
                  || (state_q == RESULT);
  assign res_valid = (state_q == RESULT);
  assign res_dist  = dist_q;
  assign res_mx    = mx_q;
  assign res_my    = my_q;
  assign err       = err_q;

  assign accept   = in_valid && in_ready;
  assign is_final = (state_q == LOAD_S)
                 && (wcnt_q == 10'(S_BYTES - 1));

  me_pixel_ram #(.DEPTH(R_BYTES), .NRD(1)) u_rmem (
    .clk_i   (clock),
    .we_i    (accept && (state_q == LOAD_R)),
    .waddr_i (wcnt_q[7:0]),
    .wdata_i (in_data),
    .raddr_i (AddressR),
    .rdata_o (R)
  );

  me_pixel_ram #(.DEPTH(S_BYTES), .NRD(2)) u_smem (
    .clk_i   (clock),
    .we_i    (accept && (state_q == LOAD_S)),
    .waddr_i (wcnt_q),
    .wdata_i (in_data),
    .raddr_i ({AddressS2, AddressS1}),
    .rdata_o (s_rd)
  );

  assign S1 = s_rd[0];
  assign S2 = s_rd[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_R;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      dist_q  <= 8'hFF;
      mx_q    <= '0;
      my_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      dist_q  <= dist_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = '0;
    dist_d  = dist_q;
    mx_d    = mx_q;
    my_d    = my_q;
    // Framing is by count; in_last only flags disagreement.
    err_d   = err_q | (accept && (in_last != is_final));
    unique case (state_q)
      LOAD_R: begin
        if (accept) begin
          if (wcnt_q[7:0] == 8'(R_BYTES - 1)) begin
            wcnt_d  = '0;
            state_d = LOAD_S;
          end else begin
            wcnt_d = wcnt_q + 10'd1;
          end
        end
      end
      LOAD_S: begin
        if (accept) begin
          if (is_final) begin
            wcnt_d  = '0;
            state_d = RUN;
          end else begin
            wcnt_d = wcnt_q + 10'd1;
          end
        end
      end
      RUN: begin
        if (completed) begin
          state_d = SETTLE;
        end else if (tcnt_q == TW'(RUN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = LOAD_R;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      SETTLE: begin
        // Engine's last comparator update has landed by now.
        dist_d  = bestDistance;
        mx_d    = motionX;
        my_d    = motionY;
        state_d = RESULT;
      end
      RESULT: begin
        if (res_ready) state_d = LOAD_R;
      end
      default: state_d = LOAD_R;
    endcase
  end
endmodule

// File: tb/tb_me_block_loader.sv
// Directed bench for me_block_loader with a stubbed ME engine.
// Covers reset, loads, readback, result handshake, framing, timeout.
module tb_me_block_loader;
  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       start;
  logic       completed;
  logic [7:0] bestDistance;
  logic [3:0] motionX;
  logic [3:0] motionY;
  logic [7:0] AddressR;
  logic [7:0] R;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic [7:0] S1;
  logic [7:0] S2;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_dist;
  logic [3:0] res_mx;
  logic [3:0] res_my;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  me_block_loader #(.RUN_TIMEOUT(4200)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .start        (start),
    .completed    (completed),
    .bestDistance (bestDistance),
    .motionX      (motionX),
    .motionY      (motionY),
    .AddressR     (AddressR),
    .R            (R),
    .AddressS1    (AddressS1),
    .AddressS2    (AddressS2),
    .S1           (S1),
    .S2           (S2),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_dist     (res_dist),
    .res_mx       (res_mx),
    .res_my       (res_my),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int i);
    logic [31:0] v;
    if (mode == 1) return 8'h10;
    if (mode == 0) v = (i < 256) ? i : i - 256;
    else           v = (i < 256) ? ~i : (i - 256) * 3;
    return v[7:0];
  endfunction

  // Streams one 1280-byte frame; returns to caller at posedge+1
  // after the final byte is accepted.
  task automatic load_frame(input int mode, input int last_at,
                            input bit gaps, output bit err_mid,
                            output bit start_pre, output bit rdy_all);
    rdy_all   = 1'b1;
    err_mid   = 1'b0;
    start_pre = 1'b0;
    for (int i = 0; i < 1280; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_data  = pix(mode, i);
      in_last  = (i == last_at);
      if (!in_ready) rdy_all = 1'b0;
      if (i == 1279) start_pre = start;
      @(posedge clock); #1;
      if (i == 999) err_mid = err;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic result(input string tag, input logic [7:0] d,
                        input logic [3:0] x, input logic [3:0] y,
                        input int stall);
    res_ready    = (stall == 0);
    bestDistance = d;
    motionX      = x;
    motionY      = y;
    completed    = 1'b1;
    @(posedge clock); #1;
    completed = 1'b0;
    chk({tag, "_settle_valid"}, res_valid, 1'b0);
    chk({tag, "_settle_start"}, start, 1'b1);
    @(posedge clock); #1;
    chk({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_dist"}, res_dist, d);
    chk({tag, "_mx"}, res_mx, x);
    chk({tag, "_my"}, res_my, y);
    bestDistance = ~d;
    motionX      = ~x;
    motionY      = ~y;
    for (int k = 0; k < stall; k++) begin
      @(posedge clock); #1;
      chk({tag, "_hold_valid"}, res_valid, 1'b1);
      chk({tag, "_hold_start"}, start, 1'b1);
      chk({tag, "_hold_res"}, {res_dist, res_mx, res_my}, {d, x, y});
    end
    res_ready = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_done_valid"}, res_valid, 1'b0);
    chk({tag, "_done_start"}, start, 1'b0);
    chk({tag, "_done_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    bit em, sp, ra;
    int cnt;
    bit saw_valid;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    completed = 1'b0; bestDistance = '0; motionX = '0; motionY = '0;
    AddressR = '0; AddressS1 = '0; AddressS2 = '0; res_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_start", start, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res", {res_dist, res_mx, res_my}, {8'hFF, 4'h0, 4'h0});
    chk("rst_err", err, 1'b0);

    // completed outside RUN must not move the FSM
    completed = 1'b1;
    @(posedge clock); #1;
    completed = 1'b0;
    chk("idle_cmp_start", start, 1'b0);
    chk("idle_cmp_ready", in_ready, 1'b1);

    // Frame 1: indexed data, readback, immediate result handshake
    load_frame(0, 1279, 1'b0, em, sp, ra);
    chk("f1_ready_all", ra, 1'b1);
    chk("f1_start_pre", sp, 1'b0);
    chk("f1_start", start, 1'b1);
    chk("f1_in_ready", in_ready, 1'b0);
    chk("f1_err", err, 1'b0);
    AddressS1 = 10'd37; AddressS2 = 10'd1023; AddressR = 8'd200;
    #1;
    chk("f1_S1", S1, 8'd37);
    chk("f1_S2", S2, 8'hFF);
    chk("f1_R", R, 8'd200);
    result("f1", 8'h2A, 4'h3, 4'hC, 0);

    // Frame 2: 50% valid, result stalled 20 cycles
    load_frame(2, 1279, 1'b1, em, sp, ra);
    chk("f2_start_pre", sp, 1'b0);
    chk("f2_start", start, 1'b1);
    AddressR = 8'd5; AddressS1 = 10'd100; AddressS2 = 10'd1023;
    #1;
    chk("f2_R", R, 8'hFA);
    chk("f2_S1", S1, 8'h2C);
    chk("f2_S2", S2, 8'hFD);
    result("f2", 8'h81, 4'hA, 4'h5, 20);

    // Frame 3: reset 100 cycles into RUN
    load_frame(1, 1279, 1'b0, em, sp, ra);
    chk("f3_start", start, 1'b1);
    repeat (100) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_start", start, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;

    // Frame 4: uniform, runs normally after the reset
    load_frame(1, 1279, 1'b0, em, sp, ra);
    chk("f4_start", start, 1'b1);
    AddressR = 8'd7; AddressS1 = 10'd500;
    #1;
    chk("f4_R", R, 8'h10);
    chk("f4_S1", S1, 8'h10);
    result("f4", 8'h00, 4'h0, 4'h0, 0);
    chk("f4_err", err, 1'b0);

    // Frame 5: engine never completes
    load_frame(1, 1279, 1'b0, em, sp, ra);
    cnt = 0;
    saw_valid = 1'b0;
    while (start && cnt < 5000) begin
      cnt++;
      if (res_valid) saw_valid = 1'b1;
      @(posedge clock); #1;
    end
    chk("to_cycles", cnt, 4200);
    chk("to_err", err, 1'b1);
    chk("to_no_valid", saw_valid, 1'b0);
    chk("to_ready", in_ready, 1'b1);

    // Clear err, then misplaced in_last on byte 1000
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("fr_err_clr", err, 1'b0);
    load_frame(0, 999, 1'b0, em, sp, ra);
    chk("fr_err_mid", em, 1'b1);
    chk("fr_start_pre", sp, 1'b0);
    chk("fr_start", start, 1'b1);
    result("fr", 8'h33, 4'h1, 4'h2, 0);
    load_frame(0, 1279, 1'b0, em, sp, ra);
    chk("fr2_start", start, 1'b1);
    result("fr2", 8'h44, 4'h4, 4'h8, 0);
    chk("fr2_err_sticky", err, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
